codec: RTL and testbench

CODEC -- requirements
Module: codec

---
 rtl/codec_if.sv | 34 +++
 rtl/codec.sv | 125 ++++++++++++
 tb/tb_codec.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/codec_if.sv
// Pixel bus between an HDMI-style source, the codec and its sink.
// Carries the per-sample mode bit, syncs, valid qualifier and N lanes of Y/Cr/Cb bytes.
interface codec_if #(
    parameter int unsigned N = 2
);
    logic              en;
    logic              i_hdmi_v_sync;
    logic              i_hdmi_h_sync;
    logic              i_hdmi_data_valid;
    logic [N-1:0][7:0] i_hdmi_data_y;
    logic [N-1:0][7:0] i_hdmi_data_cr;
    logic [N-1:0][7:0] i_hdmi_data_cb;

    logic              o_hdmi_v_sync;
    logic              o_hdmi_h_sync;
    logic              o_hdmi_data_valid;
    logic [N-1:0][7:0] o_hdmi_data_y;
    logic [N-1:0][7:0] o_hdmi_data_cr;
    logic [N-1:0][7:0] o_hdmi_data_cb;

    modport master (
        output en, i_hdmi_v_sync, i_hdmi_h_sync, i_hdmi_data_valid,
        output i_hdmi_data_y, i_hdmi_data_cr, i_hdmi_data_cb,
        input  o_hdmi_v_sync, o_hdmi_h_sync, o_hdmi_data_valid,
        input  o_hdmi_data_y, o_hdmi_data_cr, o_hdmi_data_cb
    );

    modport slave (
        input  en, i_hdmi_v_sync, i_hdmi_h_sync, i_hdmi_data_valid,
        input  i_hdmi_data_y, i_hdmi_data_cr, i_hdmi_data_cb,
        output o_hdmi_v_sync, o_hdmi_h_sync, o_hdmi_data_valid,
        output o_hdmi_data_y, o_hdmi_data_cr, o_hdmi_data_cb
    );
endinterface

// File: rtl/codec.sv
// Three-stage lossy pixel codec: 8-bit bytes quantized to 6-bit codes and rebuilt as 4q+1,
// or passed through exactly when en=0. The mode bit rides with each sample.
module codec #(
    parameter int unsigned N     = 2,
    parameter int unsigned X_RES = 2160,
    parameter int unsigned Y_RES = 1200
) (
    input logic     clk,
    input logic     rst,
    codec_if.slave  bus
);
    localparam int unsigned QW  = 6;
    localparam int unsigned CwW = 1 + 3 * N * QW;

    typedef logic [N-1:0][7:0] lanes_t;

    if (X_RES == 0 || Y_RES == 0) begin : g_bad_res
        $error("codec: X_RES and Y_RES must be non-zero");
    end

    // Stage 1: input register
    logic   en_s1_q, vs_s1_q, hs_s1_q, dv_s1_q;
    lanes_t y_s1_q, cr_s1_q, cb_s1_q;

    // Stage 2: codeword plus the parallel exact path
    logic           vs_s2_q, hs_s2_q, dv_s2_q;
    logic [CwW-1:0] cw_d, cw_q;
    lanes_t         byp_y_d, byp_cr_d, byp_cb_d;
    lanes_t         byp_y_q, byp_cr_q, byp_cb_q;

    // Stage 3: output register
    logic   o_vs_q, o_hs_q, o_dv_q;
    lanes_t out_y_d, out_cr_d, out_cb_d;
    lanes_t o_y_q, o_cr_q, o_cb_q;

    // Codeword layout, MSB first: en, cb[N-1..0], cr[N-1..0], y[N-1..0]
    always_comb begin
        cw_d          = '0;
        cw_d[CwW-1]   = en_s1_q;
        for (int l = 0; l < int'(N); l++) begin
            cw_d[l*QW +: QW]         = y_s1_q[l][7:2];
            cw_d[(N+l)*QW +: QW]     = cr_s1_q[l][7:2];
            cw_d[(2*N+l)*QW +: QW]   = cb_s1_q[l][7:2];
        end
    end

    // The exact path is zeroed in lossy mode so dropped LSBs never leave stage 1
    always_comb begin
        byp_y_d  = en_s1_q ? '0 : y_s1_q;
        byp_cr_d = en_s1_q ? '0 : cr_s1_q;
        byp_cb_d = en_s1_q ? '0 : cb_s1_q;
    end

    always_comb begin
        out_y_d  = '0;
        out_cr_d = '0;
        out_cb_d = '0;
        if (dv_s2_q) begin
            if (cw_q[CwW-1]) begin
                for (int l = 0; l < int'(N); l++) begin
                    out_y_d[l]  = {cw_q[l*QW +: QW], 2'b01};
                    out_cr_d[l] = {cw_q[(N+l)*QW +: QW], 2'b01};
                    out_cb_d[l] = {cw_q[(2*N+l)*QW +: QW], 2'b01};
                end
            end else begin
                out_y_d  = byp_y_q;
                out_cr_d = byp_cr_q;
                out_cb_d = byp_cb_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            dv_s1_q  <= 1'b0;
            y_s1_q   <= '0;
            cr_s1_q  <= '0;
            cb_s1_q  <= '0;
            vs_s2_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            dv_s2_q  <= 1'b0;
            cw_q     <= '0;
            byp_y_q  <= '0;
            byp_cr_q <= '0;
            byp_cb_q <= '0;
            o_vs_q   <= 1'b0;
            o_hs_q   <= 1'b0;
            o_dv_q   <= 1'b0;
            o_y_q    <= '0;
            o_cr_q   <= '0;
            o_cb_q   <= '0;
        end else begin
            en_s1_q  <= bus.en;
            vs_s1_q  <= bus.i_hdmi_v_sync;
            hs_s1_q  <= bus.i_hdmi_h_sync;
            dv_s1_q  <= bus.i_hdmi_data_valid;
            y_s1_q   <= bus.i_hdmi_data_y;
            cr_s1_q  <= bus.i_hdmi_data_cr;
            cb_s1_q  <= bus.i_hdmi_data_cb;
            vs_s2_q  <= vs_s1_q;
            hs_s2_q  <= hs_s1_q;
            dv_s2_q  <= dv_s1_q;
            cw_q     <= cw_d;
            byp_y_q  <= byp_y_d;
            byp_cr_q <= byp_cr_d;
            byp_cb_q <= byp_cb_d;
            o_vs_q   <= vs_s2_q;
            o_hs_q   <= hs_s2_q;
            o_dv_q   <= dv_s2_q;
            o_y_q    <= out_y_d;
            o_cr_q   <= out_cr_d;
            o_cb_q   <= out_cb_d;
        end
    end

    assign bus.o_hdmi_v_sync     = o_vs_q;
    assign bus.o_hdmi_h_sync     = o_hs_q;
    assign bus.o_hdmi_data_valid = o_dv_q;
    assign bus.o_hdmi_data_y     = o_y_q;
    assign bus.o_hdmi_data_cr    = o_cr_q;
    assign bus.o_hdmi_data_cb    = o_cb_q;
endmodule

// File: tb/tb_codec.sv
// Randomized and directed bench for codec; a per-sample reference model predicts every output
// cycle from the sample driven three edges earlier and any reset seen while it was in flight.
module tb_codec;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    codec_if #(.N(2)) bus ();
    codec #(.N(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int in_valid_cnt = 0;
    int out_valid_cnt = 0;

    typedef struct {
        bit          rst;
        bit          en;
        bit          vs;
        bit          hs;
        bit          dv;
        logic [15:0] y;
        logic [15:0] cr;
        logic [15:0] cb;
        int          tag;
    } smp_t;

    smp_t hist[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lossy reconstruction: the 4-aligned bin of x, plus one
    function automatic logic [7:0] recon(input bit en, input logic [7:0] x);
        int v;
        v = int'(x);
        if (!en) return x;
        return 8'((v / 4) * 4 + 1);
    endfunction

    function automatic logic [15:0] recon2(input bit en, input logic [15:0] w);
        return {recon(en, w[15:8]), recon(en, w[7:0])};
    endfunction

    function automatic bit err_ok(input logic [15:0] a, input logic [15:0] b);
        int d0, d1;
        d0 = int'(a[7:0]) - int'(b[7:0]);
        d1 = int'(a[15:8]) - int'(b[15:8]);
        return (d0 >= -1 && d0 <= 2 && d1 >= -1 && d1 <= 2);
    endfunction

    task automatic cycle(input bit r, input bit en, input bit vs, input bit hs, input bit dv,
                         input logic [15:0] y, input logic [15:0] cr, input logic [15:0] cb,
                         input int tag);
        smp_t        s;
        smp_t        src;
        bit          lost;
        logic [2:0]  exp_ctl;
        logic [15:0] ey, ecr, ecb;
        rst                   = r;
        bus.en                = en;
        bus.i_hdmi_v_sync     = vs;
        bus.i_hdmi_h_sync     = hs;
        bus.i_hdmi_data_valid = dv;
        bus.i_hdmi_data_y     = y;
        bus.i_hdmi_data_cr    = cr;
        bus.i_hdmi_data_cb    = cb;
        s = '{r, en, vs, hs, dv, y, cr, cb, tag};
        @(posedge clk);
        hist.push_back(s);
        if (hist.size() > 3) void'(hist.pop_front());
        #1;
        // A sample survives only if no reset edge occurred during its three stages
        lost = (hist.size() < 3);
        foreach (hist[i]) if (hist[i].rst) lost = 1'b1;
        src = hist[0];
        exp_ctl = lost ? 3'b000 : {src.vs, src.hs, src.dv};
        if (lost || !src.dv) begin
            ey = '0; ecr = '0; ecb = '0;
        end else begin
            ey  = recon2(src.en, src.y);
            ecr = recon2(src.en, src.cr);
            ecb = recon2(src.en, src.cb);
        end
        check_eq("ctl", 64'({bus.o_hdmi_v_sync, bus.o_hdmi_h_sync, bus.o_hdmi_data_valid}),
                 64'(exp_ctl));
        check_eq("y",  64'(bus.o_hdmi_data_y),  64'(ey));
        check_eq("cr", 64'(bus.o_hdmi_data_cr), 64'(ecr));
        check_eq("cb", 64'(bus.o_hdmi_data_cb), 64'(ecb));
        if (!lost && src.tag == 29) begin
            check_eq("req29_y",  64'(bus.o_hdmi_data_y),  64'h0000_0000_0000_FD01);
            check_eq("req29_cr", 64'(bus.o_hdmi_data_cr), 64'h0000_0000_0000_0505);
            check_eq("req29_cb", 64'(bus.o_hdmi_data_cb), 64'h0000_0000_0000_8101);
        end
        if (!lost && src.tag == 30) begin
            check_eq("req30_y",  64'(bus.o_hdmi_data_y),  64'h0000_0000_0000_FF00);
            check_eq("req30_cr", 64'(bus.o_hdmi_data_cr), 64'h0000_0000_0000_0607);
            check_eq("req30_cb", 64'(bus.o_hdmi_data_cb), 64'h0000_0000_0000_8003);
        end
        if (!lost && src.tag == 31 && src.dv) begin
            check_eq("ramp_err", 64'({err_ok(src.y, bus.o_hdmi_data_y),
                                      err_ok(src.cr, bus.o_hdmi_data_cr),
                                      err_ok(src.cb, bus.o_hdmi_data_cb)}), 64'h7);
        end
        if (!lost && src.dv) in_valid_cnt++;
        if (bus.o_hdmi_data_valid) out_valid_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 0);
    endtask

    initial begin
        int p;
        p = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '1, '1, '1, 0);
        idle(3);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFF00, 16'h0607, 16'h8003, 29);
        idle(4);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF00, 16'h0607, 16'h8003, 30);
        idle(4);

        // Reduced frame: ramp data, 10-cycle hsync, 2-line vsync, one mid-line reset
        for (int line = 0; line < 6; line++) begin
            for (int x = 0; x < 80; x++) begin
                logic [7:0]  b0, b1;
                logic [15:0] yv;
                bit          dv, r;
                dv = (x >= 20);
                r  = (line == 4 && x == 40);
                b0 = 8'(2 * p);
                b1 = 8'(2 * p + 1);
                yv = {b1, b0};
                cycle(r, 1'b1, line < 2, x < 10, dv, yv, yv + 16'h5555, yv + 16'hAAAA,
                      r ? 33 : 31);
                if (dv) p++;
            end
        end
        idle(4);

        // en toggles every cycle inside a valid burst
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, i[0], 1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom),
                  34);
        end
        idle(4);

        // Fully random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0);
        end
        idle(4);

        check_eq("valid_count", 64'(out_valid_cnt), 64'(in_valid_cnt));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
